period_check: RTL and testbench
===============================

PERIOD_CHECK -- requirements
Module: period_check

Interface
REQ-001 Parameter PERIOD, default 400001: expected interval in clk cycles between successive sig pulses.
REQ-002 Parameter TOL, default 2: allowed +/- deviation from PERIOD, in cycles.
REQ-003 Parameter CBITS, default 20: width of interval counter and meas; SHALL satisfy 2^CBITS-1 > PERIOD+TOL.
REQ-004 Parameter LOCKN, default 4: consecutive good periods required before locked asserts.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  enable; 0 forces IDLE.
REQ-008 sig  input  1  single-cycle event pulse from upstream period generator.
REQ-009 clr_fault  input  1  clears sticky fault; sampled only in FAULT.
REQ-010 locked  output  1  registered; high while LOCKN or more consecutive good periods seen.
REQ-011 early  output  1  registered one-cycle pulse: period shorter than PERIOD-TOL.
REQ-012 late  output  1  registered one-cycle pulse: period exceeded PERIOD+TOL.
REQ-013 fault  output  1  registered, sticky; high exactly while in FAULT.
REQ-014 pcnt  output  8  consecutive good periods, saturating at 255.
REQ-015 meas  output  CBITS  last measured interval in cycles.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_FIRST, MEASURE, FAULT.
REQ-017 IDLE: en=1 -> WAIT_FIRST next cycle; sig ignored.
REQ-018 WAIT_FIRST: sig=1 -> MEASURE, ival<=1; no check made on first pulse.
REQ-019 MEASURE, sig=0: ival<=ival+1 (saturating at 2^CBITS-1).
REQ-020 MEASURE, sig=0 and ival==PERIOD+TOL: late=1 next cycle, -> FAULT, pcnt<=0, locked<=0.
REQ-021 MEASURE, sig=1: meas<=ival, ival<=1; interval = cycles since previous sig (PERIOD for nominal source).
REQ-022 MEASURE, sig=1, ival<PERIOD-TOL: early=1 next cycle, -> FAULT, pcnt<=0, locked<=0.
REQ-023 MEASURE, sig=1, PERIOD-TOL<=ival<=PERIOD+TOL: good period; pcnt<=min(pcnt+1,255); stay in MEASURE.
REQ-024 locked SHALL be registered from updated pcnt: high the cycle after pcnt reaches LOCKN; low in every state other than MEASURE.
REQ-025 FAULT: fault=1; sig ignored; clr_fault=1 -> WAIT_FIRST if en=1, else IDLE; ival<=0.
REQ-026 en=0 in IDLE/WAIT_FIRST/MEASURE -> IDLE next cycle, ival<=0, pcnt<=0, locked<=0; meas retained.
REQ-027 en=0 in FAULT SHALL NOT exit FAULT; only clr_fault exits.
REQ-028 Simultaneous clr_fault and sig in FAULT: exit per REQ-025; that sig not counted as first pulse.
REQ-029 Simultaneous en falling and sig in MEASURE: en wins, no check, meas unchanged.
REQ-030 early and late SHALL never both be high; each high for exactly one cycle per event.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, ival=0, meas=0, pcnt=0, locked=0, early=0, late=0, fault=0, independent of clk.
REQ-032 Reset asserted mid-measurement SHALL discard partial interval; after release, first sig treated per REQ-018.
REQ-033 Outputs SHALL hold reset values until first rising clk edge after rst deasserts.

Verification (PERIOD=10, TOL=2, LOCKN=4, CBITS=8)
REQ-034 en=1, sig every 10 cycles x6 -> meas=10 after each check, pcnt 1..5, locked high cycle after 4th good period, early=late=fault=0.
REQ-035 Locked, next sig after 7 cycles -> early pulse one cycle, meas=7, fault=1, locked=0, pcnt=0.
REQ-036 Locked, sig withheld -> late pulse when ival reaches 12 without sig, fault=1; later sigs ignored until clr_fault=1, then WAIT_FIRST.
REQ-037 Boundary: intervals 8 and 12 -> both good, no fault; interval 13 -> late at ival=12.
REQ-038 rst pulsed asynchronously between clk edges during MEASURE -> all outputs 0 immediately, state IDLE; en held 1 -> WAIT_FIRST, next sig starts fresh.
REQ-039 en dropped in MEASURE coincident with sig -> IDLE, meas unchanged, pcnt=0, no early/late.

Source files
------------

// File: rtl/period_check.sv
// period_check: watches a single-cycle event pulse (sig) and checks that successive
// pulses arrive PERIOD +/- TOL clock cycles apart.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   en         enable; low returns the checker to idle (except from fault)
//   sig        single-cycle event pulse being checked
//   clr_fault  clears the sticky fault; only looked at while faulted
//   locked     high while LOCKN or more consecutive good periods have been seen
//   early      one-cycle pulse: interval shorter than PERIOD-TOL
//   late       one-cycle pulse: interval grew past PERIOD+TOL without a pulse
//   fault      sticky; high exactly while the checker is in the fault state
//   pcnt       consecutive good periods, saturating at 255
//   meas       last measured interval in cycles
module period_check #(
  parameter int unsigned PERIOD = 400001,
  parameter int unsigned TOL    = 2,
  parameter int unsigned CBITS  = 20,
  parameter int unsigned LOCKN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig,
  input  logic             clr_fault,
  output logic             locked,
  output logic             early,
  output logic             late,
  output logic             fault,
  output logic [7:0]       pcnt,
  output logic [CBITS-1:0] meas
);

  typedef enum logic [1:0] {
    StIdle,
    StWaitFirst,
    StMeasure,
    StFault
  } state_t;

  localparam logic [CBITS-1:0] IvalMin = CBITS'(PERIOD - TOL);
  localparam logic [CBITS-1:0] IvalMax = CBITS'(PERIOD + TOL);
  localparam logic [CBITS-1:0] IvalSat = '1;
  localparam logic [CBITS-1:0] IvalOne = CBITS'(1);
  localparam logic [7:0]       LockCnt = 8'(LOCKN);

  state_t           state_q;
  logic [CBITS-1:0] ival_q;
  logic [7:0]       pcnt_inc;

  assign pcnt_inc = (pcnt == 8'hff) ? pcnt : pcnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ival_q  <= '0;
      meas    <= '0;
      pcnt    <= '0;
      locked  <= 1'b0;
      early   <= 1'b0;
      late    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      // early/late are single-cycle pulses unless re-asserted below.
      early <= 1'b0;
      late  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ival_q <= '0;
          pcnt   <= '0;
          locked <= 1'b0;
          if (en) state_q <= StWaitFirst;
        end
        StWaitFirst: begin
          if (!en) begin
            state_q <= StIdle;
            ival_q  <= '0;
            pcnt    <= '0;
            locked  <= 1'b0;
          end else if (sig) begin
            // First pulse only opens the interval; nothing to check yet.
            state_q <= StMeasure;
            ival_q  <= IvalOne;
          end
        end
        StMeasure: begin
          if (!en) begin
            // Dropping enable wins over a coincident pulse; meas is retained.
            state_q <= StIdle;
            ival_q  <= '0;
            pcnt    <= '0;
            locked  <= 1'b0;
          end else if (sig) begin
            meas   <= ival_q;
            ival_q <= IvalOne;
            if (ival_q < IvalMin) begin
              early   <= 1'b1;
              fault   <= 1'b1;
              state_q <= StFault;
              pcnt    <= '0;
              locked  <= 1'b0;
            end else if (ival_q <= IvalMax) begin
              pcnt   <= pcnt_inc;
              locked <= (pcnt_inc >= LockCnt);
            end else begin
              // Only reachable if the late check were bypassed; treat as late.
              late    <= 1'b1;
              fault   <= 1'b1;
              state_q <= StFault;
              pcnt    <= '0;
              locked  <= 1'b0;
            end
          end else if (ival_q == IvalMax) begin
            late    <= 1'b1;
            fault   <= 1'b1;
            state_q <= StFault;
            pcnt    <= '0;
            locked  <= 1'b0;
          end else if (ival_q != IvalSat) begin
            ival_q <= ival_q + IvalOne;
          end
        end
        StFault: begin
          // Sticky: enable alone cannot leave, and sig is ignored here.
          if (clr_fault) begin
            fault   <= 1'b0;
            ival_q  <= '0;
            state_q <= en ? StWaitFirst : StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_check.sv
// Scoreboard bench for period_check (PERIOD=10, TOL=2, LOCKN=4, CBITS=8).
// Stimulus pushes the expected output snapshot, stamped with the cycle it must
// appear in, whenever it causes an output change; the monitor pops one entry
// for every observed change of {meas, pcnt, locked, early, late, fault}.
module tb_period_check;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sig = 1'b0;
  logic       clr_fault = 1'b0;
  logic       locked, early, late, fault;
  logic [7:0] pcnt;
  logic [7:0] meas;

  period_check #(
    .PERIOD(10),
    .TOL   (2),
    .CBITS (8),
    .LOCKN (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sig      (sig),
    .clr_fault(clr_fault),
    .locked   (locked),
    .early    (early),
    .late     (late),
    .fault    (fault),
    .pcnt     (pcnt),
    .meas     (meas)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [19:0] v;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          go = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] obs();
    return {meas, pcnt, locked, early, late, fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect output snapshot to appear in the cycle following the edge dc edges from now.
  task automatic expect_at(input int unsigned dc, input int m, input int p, input bit lk,
                           input bit er, input bit lt, input bit ft);
    exp_t e;
    e.cyc = cyc + dc;
    e.v   = {8'(m), 8'(p), lk, er, lt, ft};
    sb.push_back(e);
  endtask

  task automatic chk_out(input string name, input logic [19:0] want);
    n_chk++;
    if (obs() !== want) begin
      n_fail++;
      $display("FAIL %s: got meas/pcnt/lk/e/l/f=%h want %h", name, obs(), want);
    end
  endtask

  // Interval of n cycles since the previous sampled pulse; optionally checked.
  task automatic pulse(input int n, input bit chk, input int m, input int p, input bit lk,
                       input bit er);
    sig = 1'b0;
    repeat (n - 1) tick();
    sig = 1'b1;
    if (chk) begin
      expect_at(1, m, p, lk, er, 1'b0, er);
      if (er) expect_at(2, m, p, lk, 1'b0, 1'b0, 1'b1);
    end
    tick();
    sig = 1'b0;
  endtask

  task automatic clear(input int m);
    expect_at(1, m, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
  endtask

  // Monitor: any output change must match the head of the scoreboard.
  initial begin
    logic [19:0] prev;
    logic [19:0] cur;
    exp_t        e;
    prev = '0;
    wait (go);
    forever begin
      @(negedge clk);
      cur = obs();
      if (cur !== prev) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: cyc=%0d got %h want no change", cyc, cur);
        end else begin
          e = sb.pop_front();
          if (cur !== e.v || cyc != e.cyc || (early && late)) begin
            n_fail++;
            $display("FAIL sb_event: got cyc=%0d val=%h want cyc=%0d val=%h",
                     cyc, cur, e.cyc, e.v);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    // Reset state, held over clock edges, then still idle with en=0.
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset_hold", 20'h0);
    rst = 1'b0;
    go  = 1'b1;
    tick();
    chk_out("idle_after_reset", 20'h0);

    // Nominal 10-cycle source: five good periods, lock after the fourth.
    en = 1'b1;
    tick();
    pulse(1, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) pulse(10, 1'b1, 10, k, (k >= 4), 1'b0);

    // Early while locked: interval 7.
    pulse(7, 1'b1, 7, 0, 1'b0, 1'b1);
    repeat (3) tick();
    // clr_fault with a coincident sig: that sig must not open the interval.
    expect_at(1, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_fault = 1'b1;
    sig       = 1'b1;
    tick();
    clr_fault = 1'b0;
    sig       = 1'b0;
    pulse(5, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) pulse(10, 1'b1, 10, k, (k >= 4), 1'b0);

    // Late while locked: sig withheld, late when ival reaches 12.
    sig = 1'b0;
    expect_at(12, 10, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_at(13, 10, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (16) tick();
    for (int k = 0; k < 3; k++) begin
      sig = 1'b1;
      tick();
      sig = 1'b0;
      repeat (2) tick();
    end
    clear(10);

    // Boundaries: 8 and 12 good, 13 late at ival=12.
    pulse(1, 1'b0, 0, 0, 1'b0, 1'b0);
    pulse(8, 1'b1, 8, 1, 1'b0, 1'b0);
    pulse(12, 1'b1, 12, 2, 1'b0, 1'b0);
    expect_at(12, 12, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_at(13, 12, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (12) tick();
    sig = 1'b1;
    tick();
    sig = 1'b0;
    repeat (4) tick();
    clear(12);

    // Asynchronous reset between edges mid-measurement.
    pulse(1, 1'b0, 0, 0, 1'b0, 1'b0);
    pulse(10, 1'b1, 10, 1, 1'b0, 1'b0);
    pulse(10, 1'b1, 10, 2, 1'b0, 1'b0);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    expect_at(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk_out("async_reset", 20'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    pulse(1, 1'b0, 0, 0, 1'b0, 1'b0);
    pulse(10, 1'b1, 10, 1, 1'b0, 1'b0);

    // en dropped coincident with an (early) sig: no check, meas kept.
    pulse(10, 1'b1, 10, 2, 1'b0, 1'b0);
    repeat (4) tick();
    sig = 1'b1;
    en  = 1'b0;
    expect_at(1, 10, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    sig = 1'b0;
    repeat (3) tick();
    pulse(3, 1'b0, 0, 0, 1'b0, 1'b0);

    // en low in FAULT keeps the fault; clr_fault with en low goes to IDLE.
    en = 1'b1;
    tick();
    pulse(1, 1'b0, 0, 0, 1'b0, 1'b0);
    pulse(6, 1'b1, 6, 0, 1'b0, 1'b1);
    repeat (3) tick();
    en = 1'b0;
    repeat (5) tick();
    chk_out("fault_sticky_en_low", {8'd6, 8'd0, 4'b0001});
    clear(6);
    repeat (3) tick();
    pulse(4, 1'b0, 0, 0, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    pulse(1, 1'b0, 0, 0, 1'b0, 1'b0);
    pulse(10, 1'b1, 10, 1, 1'b0, 1'b0);
    repeat (3) tick();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
